// File: rtl/uart_rx_if.sv
// Bus-side handshake bundle for the UART receiver.
// Optional frame_err member when UART_RX_FRAME_ERR_EN is defined.
interface uart_rx_if;
    logic       go;
    logic [7:0] data;
    logic       dr;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;

    modport master (output go, input data, input dr, input frame_err);
    modport slave  (input go, output data, output dr, output frame_err);
`else
    modport master (output go, input data, input dr);
    modport slave  (input go, output data, output dr);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling, go/dr handshake to the bus side.
// Define UART_RX_FRAME_ERR_EN to add the frame_err flag (bad stop bit).
module uart_rx #(
    parameter int CLK_FREQ  = 66_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.slave  bus
);

    localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
    localparam int CW = (BIT_TIME > 2) ? $clog2(BIT_TIME) : 1;
    localparam logic [CW-1:0] HALF = CW'(BIT_TIME / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_TIME - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        WAIT_GO_LOW
    } state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [7:0]    data_q;
    logic          dr_q;
    logic          rx_s;
`ifdef UART_RX_FRAME_ERR_EN
    logic          ferr_q;
`endif

    assign rx_s = sync_q[1];

    // Input synchronizer plus receive FSM; all outputs registered.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            dr_q    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            ferr_q  <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], rx};
            case (state_q)
                IDLE: begin
                    dr_q <= 1'b0;
                    if (bus.go && !rx_s) begin
                        cnt_q   <= HALF;
                        state_q <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (!bus.go) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= FULL;
                            bit_q   <= '0;
                            state_q <= DATA_BITS;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DATA_BITS: begin
                    if (!bus.go) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        data_q[bit_q[2:0]] <= rx_s;
                        cnt_q <= FULL;
                        if (bit_q == 4'd7) begin
                            bit_q   <= '0;
                            state_q <= STOP_BIT;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                STOP_BIT: begin
                    if (!bus.go) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        dr_q    <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                        ferr_q  <= ~rx_s;
`endif
                        state_q <= WAIT_GO_LOW;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                WAIT_GO_LOW: begin
                    if (!bus.go) begin
                        dr_q    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
                        ferr_q  <= 1'b0;
`endif
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data = data_q;
    assign bus.dr   = dr_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign bus.frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at BIT_TIME=10 clocks.
// Inputs driven after posedge; outputs (negedge-updated) checked at posedge.
module tb_uart_rx;

    logic clk;
    logic rst;
    logic rx;
    int   errors;
    int   checks;
    int   first;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ  (20),
        .BAUD_RATE (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    // One 8N1 frame, 10 clocks per bit. go drops at cycle drop_at
    // (-1 = never). first = first cycle at which dr was seen high.
    task automatic send(input logic [7:0] b, input logic stop,
                        input int drop_at, output int fst);
        logic [9:0] fr;
        fr  = {stop, b, 1'b0};
        fst = -1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            if (bus.dr === 1'b1 && fst < 0) fst = c;
            if (c == drop_at) bus.go = 1'b0;
            rx = fr[c / 10];
        end
        @(posedge clk);
        if (bus.dr === 1'b1 && fst < 0) fst = 100;
        rx = 1'b1;
        cyc(3);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        rx     = 1'b0;
        bus.go = 1'b1;

        // Reset with line low and go high
        cyc(3);
        chk("rst_dr", {31'd0, bus.dr}, 32'd0);
        chk("rst_data", {24'd0, bus.data}, 32'd0);
        rx = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(30);
        chk("post_rst_dr", {31'd0, bus.dr}, 32'd0);

        // Byte 0xA5, exact dr timing
        send(8'hA5, 1'b1, -1, first);
        chk("a5_first_dr", first, 32'd98);
        chk("a5_dr", {31'd0, bus.dr}, 32'd1);
        chk("a5_data", {24'd0, bus.data}, 32'hA5);
        bus.go = 1'b0;
        cyc(1);
        chk("a5_dr_drop", {31'd0, bus.dr}, 32'd0);
        chk("a5_data_hold", {24'd0, bus.data}, 32'hA5);
        cyc(3);

        // Glitch: 3 clocks low then high
        bus.go = 1'b1;
        rx = 1'b0;
        cyc(3);
        rx = 1'b1;
        cyc(25);
        chk("glitch_dr", {31'd0, bus.dr}, 32'd0);
        send(8'h3C, 1'b1, -1, first);
        chk("3c_dr", {31'd0, bus.dr}, 32'd1);
        chk("3c_data", {24'd0, bus.data}, 32'h3C);
        bus.go = 1'b0;
        cyc(2);
        chk("3c_dr_drop", {31'd0, bus.dr}, 32'd0);

        // Handshake: frame during WAIT_GO_LOW ignored
        bus.go = 1'b1;
        send(8'hA5, 1'b1, -1, first);
        chk("hs_a5_data", {24'd0, bus.data}, 32'hA5);
        send(8'hFF, 1'b1, -1, first);
        chk("hs_ff_ignored", {24'd0, bus.data}, 32'hA5);
        chk("hs_dr_held", {31'd0, bus.dr}, 32'd1);
        bus.go = 1'b0;
        cyc(2);
        chk("hs_dr_drop", {31'd0, bus.dr}, 32'd0);
        bus.go = 1'b1;
        send(8'h00, 1'b1, -1, first);
        chk("hs_00_dr", {31'd0, bus.dr}, 32'd1);
        chk("hs_00_data", {24'd0, bus.data}, 32'h00);
        bus.go = 1'b0;
        cyc(2);

        // Abort: go drops in bit 3 of 0x55
        bus.go = 1'b1;
        send(8'h55, 1'b1, 45, first);
        chk("abort_no_dr", first, 32'hFFFFFFFF);
        cyc(10);
        chk("abort_dr", {31'd0, bus.dr}, 32'd0);
        bus.go = 1'b1;
        send(8'h81, 1'b1, -1, first);
        chk("81_dr", {31'd0, bus.dr}, 32'd1);
        chk("81_data", {24'd0, bus.data}, 32'h81);
        bus.go = 1'b0;
        cyc(2);

        // Bad stop bit on 0x7E
        bus.go = 1'b1;
        send(8'h7E, 1'b0, -1, first);
        chk("7e_dr", {31'd0, bus.dr}, 32'd1);
        chk("7e_data", {24'd0, bus.data}, 32'h7E);
`ifdef UART_RX_FRAME_ERR_EN
        chk("7e_ferr", {31'd0, bus.frame_err}, 32'd1);
`endif
        bus.go = 1'b0;
        cyc(1);
        chk("7e_dr_drop", {31'd0, bus.dr}, 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
        chk("7e_ferr_drop", {31'd0, bus.frame_err}, 32'd0);
`endif
        cyc(2);

        // Reset while waiting for go low
        bus.go = 1'b1;
        send(8'hC3, 1'b1, -1, first);
        chk("c3_data", {24'd0, bus.data}, 32'hC3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_wait_dr", {31'd0, bus.dr}, 32'd0);
        chk("rst_wait_data", {24'd0, bus.data}, 32'd0);
        cyc(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
